// File: rtl/torect_if.sv
// Sample-rate port bundle for the torect polar-to-rectangular converter.
// The master drives (mag, phase, aux) under i_ce; the slave returns (x, y, aux).
interface torect_if #(
  parameter int IW = 12,
  parameter int PW = 19,
  parameter int OW = 14
);
  logic          i_ce;
  logic [IW-1:0] i_mag;
  logic [PW-1:0] i_phase;
  logic          i_aux;
  logic [OW-1:0] o_xval;
  logic [OW-1:0] o_yval;
  logic          o_aux;

  modport master (output i_ce, i_mag, i_phase, i_aux, input o_xval, o_yval, o_aux);
  modport slave  (input i_ce, i_mag, i_phase, i_aux, output o_xval, o_yval, o_aux);
endinterface

// File: rtl/torect.sv
// Pipelined CORDIC polar-to-rectangular converter, (mag, phase) -> (x, y), one sample per i_ce.
// Optional TORECT_GAIN_COMP_EN adds a 1/K scaling stage (latency NSTAGES+3 instead of NSTAGES+2).
module torect #(
  parameter int IW      = 12,
  parameter int PW      = 19,
  parameter int OW      = 14,
  parameter int NSTAGES = 15
) (
  input  logic     i_clk,
  input  logic     i_reset_n,
  torect_if.slave  bus
);
  localparam int WW = OW + 3;
`ifdef TORECT_GAIN_COMP_EN
  localparam int LAT = NSTAGES + 3;
`else
  localparam int LAT = NSTAGES + 2;
`endif

  localparam logic [PW-1:0] QTR  = PW'(1) << (PW - 2);
  localparam logic [PW-1:0] HALF = PW'(1) << (PW - 1);
  localparam logic [PW-1:0] TQTR = QTR + HALF;

  // atan(2^-k) in units of 2^-19 turn; rescaled with rounding for other phase widths.
  localparam longint ATAN19 [0:15] = '{65536, 38688, 20442, 10377, 5208, 2607, 1304, 652,
                                       326, 163, 81, 41, 20, 10, 5, 3};
  localparam int     UPSH  = (PW >= 19) ? PW - 19 : 0;
  localparam int     DNSH  = (PW < 19) ? 19 - PW : 0;
  localparam longint RND19 = (longint'(1) << DNSH) >> 1;

  function automatic logic [PW-1:0] atan_c(input int k);
    longint v;
    v = ((ATAN19[k] << UPSH) + RND19) >> DNSH;
    return v[PW-1:0];
  endfunction

  // Round half to even, dropping the three guard bits.
  function automatic logic [OW-1:0] rnd_even(input logic signed [WW-1:0] v);
    logic up;
    up = v[2] & (v[3] | v[1] | v[0]);
    return v[WW-1:3] + OW'(up);
  endfunction

  logic signed [WW-1:0] x_q  [0:NSTAGES];
  logic signed [WW-1:0] x_d  [0:NSTAGES];
  logic signed [WW-1:0] y_q  [0:NSTAGES];
  logic signed [WW-1:0] y_d  [0:NSTAGES];
  logic        [PW-1:0] ph_q [0:NSTAGES-1];
  logic        [PW-1:0] ph_d [0:NSTAGES-1];
  logic [OW-1:0]        xo_q, xo_d, yo_q, yo_d;
  logic [LAT-1:0]       aux_pipe_q, aux_pipe_d;
  logic signed [WW-1:0] fin_x, fin_y;

  always_comb begin
    logic signed [WW-1:0] x0;
    x0      = WW'({bus.i_mag, 3'b000});
    x_d[0]  = x0;
    y_d[0]  = '0;
    ph_d[0] = bus.i_phase;
    case (bus.i_phase[PW-1 -: 3])
      3'b001, 3'b010: begin x_d[0] = '0;  y_d[0] = x0;  ph_d[0] = bus.i_phase - QTR;  end
      3'b011, 3'b100: begin x_d[0] = -x0;               ph_d[0] = bus.i_phase - HALF; end
      3'b101, 3'b110: begin x_d[0] = '0;  y_d[0] = -x0; ph_d[0] = bus.i_phase - TQTR; end
      default: ;
    endcase
    // Each micro-rotation uses only the previous stage's x and y.
    for (int k = 0; k < NSTAGES; k++) begin
      if (!ph_q[k][PW-1]) begin
        x_d[k+1] = x_q[k] - (y_q[k] >>> k);
        y_d[k+1] = y_q[k] + (x_q[k] >>> k);
      end else begin
        x_d[k+1] = x_q[k] + (y_q[k] >>> k);
        y_d[k+1] = y_q[k] - (x_q[k] >>> k);
      end
    end
    for (int k = 1; k < NSTAGES; k++)
      ph_d[k] = ph_q[k-1][PW-1] ? ph_q[k-1] + atan_c(k-1) : ph_q[k-1] - atan_c(k-1);
  end

`ifdef TORECT_GAIN_COMP_EN
  localparam int KF = 20;
  localparam logic signed [WW+KF+1:0] KINV = 636751;     // round(2^20 / 1.646760)
  localparam logic signed [WW+KF+1:0] KRND = 1 << (KF - 1);
  logic signed [WW-1:0]    xc_q, xc_d, yc_q, yc_d;
  logic signed [WW+KF+1:0] xp, yp;

  always_comb begin
    xp   = x_q[NSTAGES] * KINV + KRND;
    yp   = y_q[NSTAGES] * KINV + KRND;
    xc_d = xp[WW+KF-1:KF];
    yc_d = yp[WW+KF-1:KF];
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      xc_q <= '0;
      yc_q <= '0;
    end else if (bus.i_ce) begin
      xc_q <= xc_d;
      yc_q <= yc_d;
    end
  end

  assign fin_x = xc_q;
  assign fin_y = yc_q;
`else
  assign fin_x = x_q[NSTAGES];
  assign fin_y = y_q[NSTAGES];
`endif

  always_comb begin
    xo_d       = rnd_even(fin_x);
    yo_d       = rnd_even(fin_y);
    aux_pipe_d = {aux_pipe_q[LAT-2:0], bus.i_aux};
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      for (int k = 0; k <= NSTAGES; k++) begin
        x_q[k] <= '0;
        y_q[k] <= '0;
      end
      for (int k = 0; k < NSTAGES; k++) ph_q[k] <= '0;
      xo_q       <= '0;
      yo_q       <= '0;
      aux_pipe_q <= '0;
    end else if (bus.i_ce) begin
      x_q        <= x_d;
      y_q        <= y_d;
      ph_q       <= ph_d;
      xo_q       <= xo_d;
      yo_q       <= yo_d;
      aux_pipe_q <= aux_pipe_d;
    end
  end

  assign bus.o_xval = xo_q;
  assign bus.o_yval = yo_q;
  assign bus.o_aux  = aux_pipe_q[LAT-1];
endmodule

// File: tb/tb_torect.sv
// Bench for torect: floating-point mag*K*cos/sin model, per-cycle output checks.
module tb_torect;
  localparam int IW = 12, PW = 19, OW = 14, NST = 15;
`ifdef TORECT_GAIN_COMP_EN
  localparam int LAT  = NST + 3;
  localparam bit COMP = 1'b1;
`else
  localparam int LAT  = NST + 2;
  localparam bit COMP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  torect_if #(.IW(IW), .PW(PW), .OW(OW)) bus ();
  torect #(.IW(IW), .PW(PW), .OW(OW), .NSTAGES(NST)) dut (
    .i_clk(clk), .i_reset_n(rst_n), .bus(bus)
  );

  int    errors = 0, checks = 0;
  real   ex_q[$], ey_q[$], tol_q[$];
  bit    ea_q[$];
  string tg_q[$];
  string tag;
  real   gain;

  function automatic real kgain();
    real k = 1.0, p = 1.0;
    for (int i = 0; i < NST; i++) begin
      k = k * $sqrt(1.0 + p);
      p = p / 4.0;
    end
    return k;
  endfunction

  function automatic bit close(input int o, input real e, input real tol);
    return ((real'(o) - e) <= tol) && ((e - real'(o)) <= tol);
  endfunction

  task automatic model_clear();
    ex_q.delete(); ey_q.delete(); tol_q.delete(); ea_q.delete(); tg_q.delete();
  endtask

  task automatic push(input int mag, input int ph, input bit aux);
    real th;
    th = 2.0 * 3.14159265358979 * real'(ph) / real'(1 << PW);
    ex_q.push_back(real'(mag) * gain * $cos(th));
    ey_q.push_back(real'(mag) * gain * $sin(th));
    tol_q.push_back(mag == 0 ? 0.0 : 2.0);
    ea_q.push_back(aux);
    tg_q.push_back(tag);
  endtask

  // The output after n accepted edges belongs to accepted sample n-LAT, else reset zeros.
  task automatic check_out();
    int n, i, ox, oy;
    n = ex_q.size();
    if (n < LAT) begin
      checks++;
      assert (bus.o_xval === '0) else begin errors++; $error("FAIL %s x: got %0d want 0", tag, $signed(bus.o_xval)); end
      checks++;
      assert (bus.o_yval === '0) else begin errors++; $error("FAIL %s y: got %0d want 0", tag, $signed(bus.o_yval)); end
      checks++;
      assert (bus.o_aux === 1'b0) else begin errors++; $error("FAIL %s aux: got %b want 0", tag, bus.o_aux); end
    end else begin
      i  = n - LAT;
      ox = $signed(bus.o_xval);
      oy = $signed(bus.o_yval);
      checks++;
      assert (close(ox, ex_q[i], tol_q[i])) else begin errors++; $error("FAIL %s#%0d x: got %0d want %f", tg_q[i], i, ox, ex_q[i]); end
      checks++;
      assert (close(oy, ey_q[i], tol_q[i])) else begin errors++; $error("FAIL %s#%0d y: got %0d want %f", tg_q[i], i, oy, ey_q[i]); end
      checks++;
      assert (bus.o_aux === ea_q[i]) else begin errors++; $error("FAIL %s#%0d aux: got %b want %b", tg_q[i], i, bus.o_aux, ea_q[i]); end
    end
  endtask

  task automatic step(input bit ce, input int mag, input int ph, input bit aux);
    bus.i_ce    = ce;
    bus.i_mag   = IW'(mag);
    bus.i_phase = PW'(ph);
    bus.i_aux   = aux;
    @(posedge clk);
    #1;
    if (rst_n && ce) push(mag, ph, aux);
    check_out();
  endtask

  initial begin
    int dm [0:8];
    int dp [0:8];
    string dt [0:8];
    int s;
    bit ce;

    gain  = COMP ? 1.0 : kgain();
    rst_n = 1'b0;
    bus.i_ce = 1'b0; bus.i_mag = '0; bus.i_phase = '0; bus.i_aux = 1'b0;
    tag = "reset";
    #2;
    for (int i = 0; i < 2; i++)
      step(1'($urandom_range(0, 1)), $urandom_range(0, 4095), $urandom_range(0, (1 << PW) - 1), 1'b1);
    #2 rst_n = 1'b1;

    dm = '{1000, 1000, 1000, 1000, 1000, 1000, 1000, 1000, 4095};
    dp = '{0, 1 << 17, 1 << 18, 3 << 17, 1 << 16, (1 << 19) - 1, 'h1FFFF, 'h20000, 0};
    dt = '{"card0", "card90", "card180", "card270", "oct45", "wrap", "oct_lo", "oct_hi", "fullscale"};
    for (int i = 0; i < 9; i++) begin
      tag = dt[i];
      step(1'b1, dm[i], dp[i], 1'b0);
    end
    tag = "magzero";
    for (int i = 0; i < 6; i++) step(1'b1, 0, $urandom_range(0, (1 << PW) - 1), 1'b0);
    tag = "flush";
    for (int i = 0; i < LAT; i++) step(1'b1, $urandom_range(0, 4095), $urandom_range(0, (1 << PW) - 1), 1'b0);

    // Twenty accepted samples, aux on sample 3 only, stalls on random cycles.
    tag = "ce_aux";
    s = 0;
    while (s < 20) begin
      ce = ($urandom_range(0, 3) != 0);
      step(ce, $urandom_range(0, 4095), $urandom_range(0, (1 << PW) - 1),
           ce ? (s == 3) : 1'($urandom_range(0, 1)));
      if (ce) s++;
    end
    tag = "ce_drain";
    for (int i = 0; i < 40; i++)
      step(1'($urandom_range(0, 2) != 0), $urandom_range(0, 4095), $urandom_range(0, (1 << PW) - 1), 1'b0);

    tag = "inflight";
    for (int i = 0; i < 10; i++) step(1'b1, $urandom_range(1, 4095), $urandom_range(0, (1 << PW) - 1), 1'b1);
    #3 rst_n = 1'b0;
    #1;
    model_clear();
    tag = "midreset";
    check_out();
    for (int i = 0; i < 3; i++)
      step(1'b1, $urandom_range(0, 4095), $urandom_range(0, (1 << PW) - 1), 1'b1);
    #2 rst_n = 1'b1;
    tag = "postreset";
    for (int i = 0; i < LAT + 8; i++)
      step(1'b1, $urandom_range(1, 4095), $urandom_range(0, (1 << PW) - 1), i == 0);

    tag = "random";
    for (int i = 0; i < 80; i++)
      step(1'($urandom_range(0, 3) != 0), ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(0, 4095),
           $urandom_range(0, (1 << PW) - 1), 1'($urandom_range(0, 1)));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
